traffic_light_monitor: RTL

- Passive checker on the four light buses driven by traffic_control.
- Samples n/s/e/w lights every clock and verifies one-hot encoding, mutual exclusion, green->yellow->red sequencing, and yellow/green durations.
- Raises sticky error flags and counts completed green grants.
- Instantiated beside traffic_control in benches and in the top level for on-chip safety status. Never drives the lights.

---
 rtl/traffic_light_monitor.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
//   Passive safety checker for the four light buses of traffic_control.
//   The lights are registered once and every check runs on that registered
//   copy. Error flags, the sequencing FSM and the grant counter update one
//   edge later, so a bad input shows up on the flags two edges after it is
//   applied. The monitor never drives the lights.
//
//   Optional build macro: TRAFFIC_MON_ORDER_CHECK_EN
//     When defined, grants must rotate N->S->E->W->N. The first grant after
//     reset or after the FSM has been in IDLE is exempt and seeds the order.
//
// Ports
//   clk           system clock, rising edge
//   rst_a         asynchronous active-low reset
//   n/s/e/w_lights {red,yellow,green} per direction (bit2=red, bit0=green)
//   clr_err       one-cycle pulse clearing the sticky error flags and err_dir
//   err_code      sticky: a light bus was not one-hot
//   err_conflict  sticky: more than one direction was non-red
//   err_seq       sticky: illegal colour transition
//   err_timing    sticky: yellow or green duration out of range
//   err_any       OR of the four error flags
//   err_dir       direction of the first error since reset/clear (0=N..3=W)
//   active_dir    direction holding green/yellow
//   active_valid  active_dir is meaningful (FSM in GREEN or YELLOW)
//   grant_cnt     count of legal green->yellow handovers, wraps
module traffic_light_monitor #(
    parameter int YEL_MIN = 2,
    parameter int YEL_MAX = 8,
    parameter int GRN_MAX = 64,
    parameter int DUR_W   = 8,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_a,
    input  logic [2:0]       n_lights,
    input  logic [2:0]       s_lights,
    input  logic [2:0]       e_lights,
    input  logic [2:0]       w_lights,
    input  logic             clr_err,
    output logic             err_code,
    output logic             err_conflict,
    output logic             err_seq,
    output logic             err_timing,
    output logic             err_any,
    output logic [1:0]       err_dir,
    output logic [1:0]       active_dir,
    output logic             active_valid,
    output logic [CNT_W-1:0] grant_cnt
);

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;

    localparam logic [DUR_W-1:0] DUR_SAT   = '1;
    localparam logic [DUR_W-1:0] YEL_MIN_D = DUR_W'(YEL_MIN);
    localparam logic [DUR_W-1:0] YEL_MAX_D = DUR_W'(YEL_MAX);
    localparam logic [DUR_W-1:0] GRN_LIM   = DUR_W'(GRN_MAX + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ALL_RED = 2'd1,
        GREEN   = 2'd2,
        YELLOW  = 2'd3
    } state_t;

    // Lowest set bit wins, which gives the N>S>E>W priority for err_dir.
    function automatic logic [1:0] first_idx(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    function automatic logic [DUR_W-1:0] sat_inc(input logic [DUR_W-1:0] v);
        return (v == DUR_SAT) ? v : v + DUR_W'(1);
    endfunction

    logic [2:0]       lights_p0 [4];
    state_t           state, state_n;
    logic [DUR_W-1:0] dur, dur_n;
    logic [1:0]       active_n;
    logic [CNT_W-1:0] grant_n;

    logic [3:0] is_red, is_yel, is_grn, bad_code, nonred;
    logic       set_code, set_conf, set_seq, set_tim, set_any;
    logic [3:0] seq_vec, err_vec;
    logic [1:0] grn_dir;
    logic [2:0] act;

`ifdef TRAFFIC_MON_ORDER_CHECK_EN
    logic [1:0] last_dir, last_dir_n;
    logic       order_seeded, order_seeded_n;
`endif

    // ---- stage p0: decode of the registered light samples ----
    always_comb begin
        for (int d = 0; d < 4; d++) begin
            is_red[d]   = (lights_p0[d] == RED);
            is_yel[d]   = (lights_p0[d] == YEL);
            is_grn[d]   = (lights_p0[d] == GRN);
            bad_code[d] = !(is_red[d] || is_yel[d] || is_grn[d]);
        end
    end

    assign nonred   = ~is_red;
    assign set_code = |bad_code;
    // v & (v-1) is non-zero exactly when two or more bits are set.
    assign set_conf = |(nonred & (nonred - 4'd1));
    assign grn_dir  = first_idx(is_grn);
    assign act      = lights_p0[active_dir];

    // ---- stage p1: FSM next state, duration and sequencing checks ----
    always_comb begin
        state_n  = state;
        dur_n    = sat_inc(dur);
        active_n = active_dir;
        grant_n  = grant_cnt;
        set_seq  = 1'b0;
        set_tim  = 1'b0;
        seq_vec  = 4'd0;
`ifdef TRAFFIC_MON_ORDER_CHECK_EN
        last_dir_n     = last_dir;
        order_seeded_n = order_seeded;
`endif

        // Encoding and conflict faults pre-empt every FSM transition.
        if (set_code || set_conf) begin
            state_n = IDLE;
            dur_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (&is_red) begin
                        state_n = ALL_RED;
                        dur_n   = '0;
                    end
                end
                ALL_RED: begin
                    if (|is_grn) begin
                        state_n  = GREEN;
                        active_n = grn_dir;
                        dur_n    = DUR_W'(1);
`ifdef TRAFFIC_MON_ORDER_CHECK_EN
                        // Out-of-turn grant is flagged but still tracked.
                        if (order_seeded && (grn_dir != last_dir + 2'd1)) begin
                            set_seq = 1'b1;
                            seq_vec = 4'b0001 << grn_dir;
                        end
                        last_dir_n     = grn_dir;
                        order_seeded_n = 1'b1;
`endif
                    end else if (|is_yel) begin
                        set_seq = 1'b1;
                        seq_vec = is_yel;
                        state_n = IDLE;
                        dur_n   = '0;
                    end
                end
                GREEN: begin
                    if (act == YEL) begin
                        state_n = YELLOW;
                        grant_n = grant_cnt + CNT_W'(1);
                        dur_n   = DUR_W'(1);
                    end else if (act == RED) begin
                        set_seq = 1'b1;
                        seq_vec = 4'b0001 << active_dir;
                        state_n = ALL_RED;
                        dur_n   = '0;
                    end else if (dur_n == GRN_LIM) begin
                        // The counter passes GRN_LIM only once per green.
                        set_tim = 1'b1;
                    end
                end
                YELLOW: begin
                    if (act == RED) begin
                        set_tim = (dur < YEL_MIN_D) || (dur > YEL_MAX_D);
                        state_n = ALL_RED;
                        dur_n   = '0;
                    end else if (act == GRN) begin
                        set_seq = 1'b1;
                        seq_vec = 4'b0001 << active_dir;
                        state_n = GREEN;
                        dur_n   = DUR_W'(1);
                    end
                end
                default: state_n = IDLE;
            endcase
        end

`ifdef TRAFFIC_MON_ORDER_CHECK_EN
        if (state_n == IDLE) begin
            order_seeded_n = 1'b0;
        end
`endif
    end

    assign err_vec = bad_code | (set_conf ? nonred : 4'd0) | seq_vec |
                     (set_tim ? (4'b0001 << active_dir) : 4'd0);
    assign set_any = set_code | set_conf | set_seq | set_tim;

    assign err_any      = err_code | err_conflict | err_seq | err_timing;
    assign active_valid = (state == GREEN) || (state == YELLOW);

    // ---- stage p0 capture and p1 state/flag registers ----
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            for (int d = 0; d < 4; d++) begin
                lights_p0[d] <= RED;
            end
            state        <= IDLE;
            dur          <= '0;
            active_dir   <= 2'd0;
            grant_cnt    <= '0;
            err_code     <= 1'b0;
            err_conflict <= 1'b0;
            err_seq      <= 1'b0;
            err_timing   <= 1'b0;
            err_dir      <= 2'd0;
        end else begin
            lights_p0[0] <= n_lights;
            lights_p0[1] <= s_lights;
            lights_p0[2] <= e_lights;
            lights_p0[3] <= w_lights;
            state        <= state_n;
            dur          <= dur_n;
            active_dir   <= active_n;
            grant_cnt    <= grant_n;
            // A new error in the clear cycle survives the clear.
            err_code     <= (err_code     & ~clr_err) | set_code;
            err_conflict <= (err_conflict & ~clr_err) | set_conf;
            err_seq      <= (err_seq      & ~clr_err) | set_seq;
            err_timing   <= (err_timing   & ~clr_err) | set_tim;
            if (set_any && (!err_any || clr_err)) begin
                err_dir <= first_idx(err_vec);
            end else if (clr_err) begin
                err_dir <= 2'd0;
            end
        end
    end

`ifdef TRAFFIC_MON_ORDER_CHECK_EN
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            last_dir     <= 2'd0;
            order_seeded <= 1'b0;
        end else begin
            last_dir     <= last_dir_n;
            order_seeded <= order_seeded_n;
        end
    end
`endif

endmodule
